// File: rtl/majority_voter.sv
// N-input majority / threshold voter with a two-stage valid/ready pipeline.
// Optional disagreement counter enabled by defining MAJ_DISAGREE_CNT_EN.
`timescale 1ns/1ps
module majority_voter #(
  parameter  int N  = 5,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_vec,
  input  logic          mode,
  input  logic [CW-1:0] thr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_z,
  output logic [CW-1:0] out_count,
  output logic          out_unanimous
`ifdef MAJ_DISAGREE_CNT_EN
  ,
  output logic [15:0]   disagree_cnt,
  input  logic          cnt_clr
`endif
);

  localparam logic [CW-1:0] HALF = CW'(N / 2);

  logic          s1_valid_reg;
  logic [CW-1:0] s1_count_reg;
  logic          s1_mode_reg;
  logic [CW-1:0] s1_thr_reg;
  logic          s1_unan_reg;

  logic          s2_valid_reg;
  logic          s2_z_reg;
  logic [CW-1:0] s2_count_reg;
  logic          s2_unan_reg;

  logic [CW-1:0] pop_count;
  logic          s2_advance;
  logic          decision;

  always_comb begin
    pop_count = '0;
    for (int i = 0; i < N; i++) begin
      pop_count = pop_count + CW'(in_vec[i]);
    end
  end

  // A stalled output only blocks input once S1 is also occupied.
  assign s2_advance = !s2_valid_reg || out_ready;
  assign in_ready   = !s1_valid_reg || s2_advance;

  assign decision = s1_mode_reg ? (s1_count_reg >= s1_thr_reg)
                                : (s1_count_reg > HALF);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_count_reg <= '0;
      s1_mode_reg  <= 1'b0;
      s1_thr_reg   <= '0;
      s1_unan_reg  <= 1'b0;
    end else if (in_ready) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_count_reg <= pop_count;
        s1_mode_reg  <= mode;
        s1_thr_reg   <= thr;
        s1_unan_reg  <= (in_vec == '0) || (in_vec == '1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_z_reg     <= 1'b0;
      s2_count_reg <= '0;
      s2_unan_reg  <= 1'b0;
    end else if (s2_advance) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_z_reg     <= decision;
        s2_count_reg <= s1_count_reg;
        s2_unan_reg  <= s1_unan_reg;
      end
    end
  end

  assign out_valid     = s2_valid_reg;
  assign out_z         = s2_z_reg;
  assign out_count     = s2_count_reg;
  assign out_unanimous = s2_unan_reg;

`ifdef MAJ_DISAGREE_CNT_EN
  logic [15:0] disagree_cnt_reg;

  // Clear beats a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      disagree_cnt_reg <= '0;
    end else if (cnt_clr) begin
      disagree_cnt_reg <= '0;
    end else if (s2_valid_reg && out_ready && !s2_unan_reg &&
                 (disagree_cnt_reg != 16'hFFFF)) begin
      disagree_cnt_reg <= disagree_cnt_reg + 16'd1;
    end
  end

  assign disagree_cnt = disagree_cnt_reg;
`endif

endmodule

// File: tb/tb_majority_voter.sv
// Scoreboard bench for majority_voter (N=5): directed vectors, a stall window,
// reset with items in flight, and the disagreement counter when compiled in.
`timescale 1ns/1ps
module tb_majority_voter;
  localparam int N  = 5;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_vec;
  logic          mode;
  logic [CW-1:0] thr;
  logic          out_valid;
  logic          out_ready;
  logic          out_z;
  logic [CW-1:0] out_count;
  logic          out_unanimous;
`ifdef MAJ_DISAGREE_CNT_EN
  logic [15:0]   disagree_cnt;
  logic          cnt_clr;
`endif

  typedef struct packed {
    logic          z;
    logic [CW-1:0] count;
    logic          unan;
    logic [31:0]   id;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   n_out = 0;
  int   id_ctr = 0;
  logic ready_q = 1'b1;
  logic verbose = 1'b1;

  majority_voter #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_vec       (in_vec),
    .mode         (mode),
    .thr          (thr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_z        (out_z),
    .out_count    (out_count),
    .out_unanimous(out_unanimous)
`ifdef MAJ_DISAGREE_CNT_EN
    ,
    .disagree_cnt (disagree_cnt),
    .cnt_clr      (cnt_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // out_ready follows ready_q, changing just after each rising edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 out_ready = ready_q;
    end
  end

  // Monitor: pops the scoreboard on each output handshake, checks hold under stall.
  initial begin
    logic        hold_v;
    logic [31:0] hold_d;
    exp_t        e;
    hold_v = 1'b0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
        continue;
      end
      if (hold_v)
        check("hold_stable", 32'({out_valid, out_z, out_count, out_unanimous}), hold_d);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got z=%0d count=%0d unan=%0d, expected no output",
                   out_z, out_count, out_unanimous);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("item%0d", e.id), 32'({out_z, out_count, out_unanimous}),
                32'({e.z, e.count, e.unan}));
          if (verbose)
            $display("[TB] out item%0d z=%0d count=%0d unan=%0d", e.id, out_z, out_count,
                     out_unanimous);
          n_out++;
        end
        hold_v = 1'b0;
      end else if (out_valid) begin
        hold_v = 1'b1;
        hold_d = 32'({1'b1, out_z, out_count, out_unanimous});
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  task automatic send(input logic [N-1:0] v, input logic m, input logic [CW-1:0] t,
                      input logic ez, input logic [CW-1:0] ec, input logic eu);
    int waited = 0;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_vec   = v;
    mode     = m;
    thr      = t;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready=0 after 50 cycles, expected 1 (item%0d)", id_ctr);
    end else begin
      e = '{z: ez, count: ec, unan: eu, id: 32'(id_ctr)};
      sb_q.push_back(e);
      if (verbose)
        $display("[TB] in  item%0d vec=%b mode=%0d thr=%0d", id_ctr, v, m, t);
      id_ctr++;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int waited = 0;
    while (sb_q.size() != 0 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_drained"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base;
    logic saw_stall;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_vec   = 5'b11111;
    mode     = 1'b0;
    thr      = '0;
`ifdef MAJ_DISAGREE_CNT_EN
    cnt_clr  = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_z", 32'(out_z), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_unan", 32'(out_unanimous), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef MAJ_DISAGREE_CNT_EN
    check("rst_disagree_cnt", 32'(disagree_cnt), 32'd0);
`endif
    repeat (2) @(negedge clk);
    check("rst_ignores_in_valid", 32'(out_valid), 32'd0);

    // Latency: accepted at the next edge, visible two edges later.
    send(5'b10110, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0);
    idle();
    check("lat_cycle1_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2_out_valid", 32'(out_valid), 32'd1);
    drain("lat");

    send(5'b00000, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1);
    send(5'b11111, 1'b1, 3'd6, 1'b0, 3'd5, 1'b1);
    send(5'b00011, 1'b0, 3'd0, 1'b0, 3'd2, 1'b0);
    send(5'b00111, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0);
    send(5'b00111, 1'b1, 3'd4, 1'b0, 3'd3, 1'b0);
    send(5'b11111, 1'b0, 3'd0, 1'b1, 3'd5, 1'b1);
    send(5'b00000, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    send(5'b11000, 1'b1, 3'd7, 1'b0, 3'd2, 1'b0);
    idle();
    drain("directed");

    // Eight back-to-back items with out_ready low for three cycles.
    base = n_out;
    saw_stall = 1'b0;
    fork
      begin
        send(5'b00001, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0);
        send(5'b00011, 1'b0, 3'd0, 1'b0, 3'd2, 1'b0);
        send(5'b00111, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0);
        send(5'b01111, 1'b0, 3'd0, 1'b1, 3'd4, 1'b0);
        send(5'b11111, 1'b0, 3'd0, 1'b1, 3'd5, 1'b1);
        send(5'b00000, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
        send(5'b10101, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0);
        send(5'b01010, 1'b1, 3'd3, 1'b0, 3'd2, 1'b0);
        idle();
      end
      begin
        for (int c = 0; c < 14; c++) begin
          @(negedge clk);
          if (!in_ready) saw_stall = 1'b1;
          ready_q = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
        end
      end
    join
    drain("stream");
    check("stream_in_ready_dropped", 32'(saw_stall), 32'd1);
    check("stream_count", 32'(n_out - base), 32'd8);

    // Reset with two items in flight.
    ready_q = 1'b0;
    repeat (2) @(negedge clk);
    send(5'b11100, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0);
    send(5'b00100, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    base = n_out;
    ready_q = 1'b1;
    repeat (6) @(negedge clk);
    check("flush_no_stale", 32'(n_out - base), 32'd0);

`ifdef MAJ_DISAGREE_CNT_EN
    send(5'b10110, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0);
    send(5'b00011, 1'b0, 3'd0, 1'b0, 3'd2, 1'b0);
    send(5'b01000, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0);
    send(5'b11111, 1'b0, 3'd0, 1'b1, 3'd5, 1'b1);
    idle();
    drain("cnt");
    @(negedge clk);
    check("disagree_cnt_3", 32'(disagree_cnt), 32'd3);

    ready_q = 1'b0;
    repeat (2) @(negedge clk);
    send(5'b00011, 1'b0, 3'd0, 1'b0, 3'd2, 1'b0);
    idle();
    repeat (2) @(negedge clk);
    ready_q = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("disagree_cnt_clr_wins", 32'(disagree_cnt), 32'd0);
    drain("clr");

    verbose = 1'b0;
    for (int i = 0; i < 65535; i++)
      send(5'b00011, 1'b0, 3'd0, 1'b0, 3'd2, 1'b0);
    idle();
    drain("sat_fill");
    @(negedge clk);
    check("disagree_cnt_full", 32'(disagree_cnt), 32'hFFFF);
    send(5'b00011, 1'b0, 3'd0, 1'b0, 3'd2, 1'b0);
    idle();
    drain("sat_extra");
    @(negedge clk);
    check("disagree_cnt_saturate", 32'(disagree_cnt), 32'hFFFF);
    verbose = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/majority_voter.md
MAJORITY_VOTER -- requirements
Module: majority_voter

Interface
REQ-001 Parameter N, default 5, number of voter inputs; legal 3..31.
REQ-002 Parameter CW, default $clog2(N+1), width of count/threshold fields; derived, not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  in_vec/mode/thr valid this cycle.
REQ-006 in_ready  output  1  block accepts input this cycle.
REQ-007 in_vec  input  N  voter inputs, bit i = voter i.
REQ-008 mode  input  1  0 = simple majority, 1 = programmable threshold.
REQ-009 thr  input  CW  threshold for mode 1.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 out_z  output  1  vote decision.
REQ-013 out_count  output  CW  number of ones in accepted in_vec.
REQ-014 out_unanimous  output  1  in_vec was all-ones or all-zeros.
REQ-015 disagree_cnt  output  16  non-unanimous result counter (present only with macro, REQ-036).
REQ-016 cnt_clr  input  1  clears disagree_cnt (present only with macro).

Function
REQ-017 Input accepted on cycle where in_valid && in_ready; mode and thr sampled with in_vec and carried with that item.
REQ-018 Two-stage pipeline: S1 registers in_vec popcount, mode, thr, unanimity; S2 registers out_z, out_count, out_unanimous.
REQ-019 Latency: accepted item appears on out_valid exactly 2 cycles after acceptance when out_ready held high.
REQ-020 Throughput: one item per cycle sustained with out_ready high.
REQ-021 S2 advances when !out_valid || out_ready; S1 advances into S2 under same condition.
REQ-022 in_ready = !s1_valid || (s2 advancing); in_ready is combinational from out_ready only, never from in_valid.
REQ-023 out_valid, out_z, out_count, out_unanimous held stable while out_valid && !out_ready.
REQ-024 Mode 0: out_z = 1 iff count > N/2 (integer division); even N tie gives 0.
REQ-025 Mode 1: out_z = 1 iff count >= thr; thr = 0 gives 1; thr > N gives 0.
REQ-026 out_unanimous = 1 iff count == 0 or count == N.
REQ-027 No item dropped or duplicated under any in_valid/out_ready pattern.
REQ-028 Bubbles: S1/S2 valid flags clear when drained without new input.

Reset
REQ-029 rst high at a clock edge clears S1 and S2 valid flags; in-flight items discarded.
REQ-030 Reset values: out_valid 0, out_z 0, out_count 0, out_unanimous 0, disagree_cnt 0.
REQ-031 in_ready = 1 in the first cycle after reset deasserts.
REQ-032 rst overrides in_valid, out_ready and cnt_clr in the same cycle.

Configuration
REQ-033 Macro MAJ_DISAGREE_CNT_EN controls the disagreement counter.
REQ-034 With macro: disagree_cnt increments by 1 on each output handshake (out_valid && out_ready) with out_unanimous = 0.
REQ-035 With macro: counter saturates at 0xFFFF; cnt_clr clears to 0 and wins over simultaneous increment.
REQ-036 Without macro: disagree_cnt and cnt_clr ports absent, no counter logic; all other behaviour identical.

Verification
REQ-037 N=5, mode 0, in_vec 5'b10110, out_ready 1 -> out_valid 2 cycles after accept, out_z 1, out_count 3, out_unanimous 0.
REQ-038 N=5, mode 1, thr 0 with in_vec 0, then thr 6 with in_vec 5'b11111 -> out_z 1 then 0; out_unanimous 1 both.
REQ-039 Back-to-back 8 items, out_ready low cycles 3-5 -> in_ready drops after pipeline fills, all 8 results in order, none lost.
REQ-040 rst pulsed with two items in flight -> out_valid 0 next cycle, no stale result emitted after reset.
REQ-041 With MAJ_DISAGREE_CNT_EN: 3 non-unanimous + 1 unanimous handshaken -> disagree_cnt 3; cnt_clr with concurrent increment -> 0; preload to 0xFFFF and increment -> stays 0xFFFF.
